lut_stream_loader: RTL

- Writable lookup table with a streaming load port. Run-time counterpart of the team's file-initialised ROM: it writes table contents instead of reading preloaded ones.
- A host/DMA-side producer pushes words over valid/ready. They are written to consecutive addresses starting at 0.
- The datapath reads the table through a registered port with the same timing as the ROM: 1-cycle latency.
- Used to reprogram step-response / impulse tables in the link emulator without rebuilding the bitstream.

---
 rtl/lut_stream_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lut_stream_loader.sv
// Writable LUT: consecutive-address stream loader plus 1-cycle registered read port (read-first).
// Loader stalls the producer via in_ready outside LOAD; optional checksum port under LUT_LOADER_CHECKSUM_EN.
module lut_stream_loader #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_start,
  input  logic [ADDR_BITS:0]   i_load_len,
  input  logic                 i_in_valid,
  input  logic [DATA_BITS-1:0] i_in_data,
  output logic                 o_in_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_table_valid,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [DATA_BITS-1:0] o_dout
`ifdef LUT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_BITS+ADDR_BITS-1:0] o_checksum
`endif
);

  localparam int DEPTH_WORDS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_BITS:0]     r_len;
  logic [ADDR_BITS:0]     r_count;
  logic [ADDR_BITS-1:0]   r_wr_ptr;
  logic                   r_table_valid;
  logic [DATA_BITS-1:0]   r_dout;
  logic [DATA_BITS-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_BITS:0]     w_len_sat;
  logic [ADDR_BITS:0]     w_count_inc;
  logic                   w_start;
  logic                   w_accept;
  logic                   w_last;

  assign w_len_sat   = (i_load_len > DEPTH) ? DEPTH : i_load_len;
  assign w_count_inc = r_count + 1'b1;
  assign w_start     = (r_state == S_IDLE) && i_load_start;
  assign w_accept    = i_in_valid && o_in_ready && !i_rst;
  assign w_last      = (w_count_inc == r_len);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_load_start) begin
          w_next_state = (w_len_sat == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len         <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_table_valid <= 1'b0;
    end else if (w_start) begin
      r_len         <= w_len_sat;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_table_valid <= 1'b0;
    end else if (w_accept) begin
      // A full-depth load wraps the pointer back to 0; nothing is written after that.
      r_count  <= w_count_inc;
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end else if (r_state == S_DONE) begin
      r_table_valid <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Read sees the pre-write word on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_table_valid = r_table_valid;
  assign o_dout        = r_dout;

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [DATA_BITS+ADDR_BITS-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + {{ADDR_BITS{1'b0}}, i_in_data};
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule
